// File: rtl/gpu_draw_scheduler.sv
// Draw command front end: queues commands, issues one to the rectangle stage, holds
// per-draw configuration until all pixels of the draw are written. Option: GPU_SCHED_TIMEOUT_EN.
module gpu_draw_scheduler #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [15:0]                 cmd_start_x,
    input  logic [15:0]                 cmd_start_y,
    input  logic [15:0]                 cmd_width,
    input  logic [15:0]                 cmd_height,
    input  logic [15:0]                 cmd_scale_x,
    input  logic [15:0]                 cmd_scale_y,
    input  logic                        cmd_mirror_x,
    input  logic                        cmd_mirror_y,
    input  logic [31:0]                 cmd_base_address,
    input  logic [15:0]                 cmd_image_width,
    input  logic [4:0]                  cmd_ct_type,
    input  logic                        cmd_use_ct,
    input  logic [15:0]                 cmd_ct_base_address,
    output logic                        rect_valid,
    input  logic                        rect_ready,
    output logic [15:0]                 rect_start_x,
    output logic [15:0]                 rect_start_y,
    output logic [15:0]                 rect_width,
    output logic [15:0]                 rect_height,
    output logic [15:0]                 rect_scale_x,
    output logic [15:0]                 rect_scale_y,
    output logic                        rect_mirror_x,
    output logic                        rect_mirror_y,
    output logic [31:0]                 cfg_base_address,
    output logic [15:0]                 cfg_image_width,
    output logic [4:0]                  cfg_ct_type,
    output logic                        cfg_use_ct,
    output logic [15:0]                 cfg_ct_base_address,
    input  logic                        fb_write,
    output logic                        busy,
    output logic                        draw_done,
    output logic [$clog2(FIFO_DEPTH):0] pending
`ifdef GPU_SCHED_TIMEOUT_EN
    ,
    output logic                        sched_error
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CMD_W = 168;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("gpu_draw_scheduler: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t           state, state_next;
    logic [CMD_W-1:0] mem [FIFO_DEPTH];
    logic [CMD_W-1:0] cmd_word, head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty, push, pop, done_next;
    logic [31:0]      head_total, total, pix_count;

    logic [15:0] h_start_x, h_start_y, h_width, h_height, h_scale_x, h_scale_y;
    logic        h_mirror_x, h_mirror_y, h_use_ct;
    logic [31:0] h_base_address;
    logic [15:0] h_image_width, h_ct_base_address;
    logic [4:0]  h_ct_type;

    assign cmd_word = {cmd_start_x, cmd_start_y, cmd_width, cmd_height, cmd_scale_x, cmd_scale_y,
                       cmd_mirror_x, cmd_mirror_y, cmd_base_address, cmd_image_width,
                       cmd_ct_type, cmd_use_ct, cmd_ct_base_address};
    assign head = mem[rd_ptr];
    assign {h_start_x, h_start_y, h_width, h_height, h_scale_x, h_scale_y,
            h_mirror_x, h_mirror_y, h_base_address, h_image_width,
            h_ct_type, h_use_ct, h_ct_base_address} = head;
    assign head_total = 32'(h_width) * 32'(h_height);

    assign full      = (pending == CNT_W'(FIFO_DEPTH));
    assign empty     = (pending == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || !empty;

`ifdef GPU_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
    logic            err_set;
`endif

    // Command queue storage; data needs no reset since pending gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   pending <= pending + CNT_W'(1);
                2'b01:   pending <= pending - CNT_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        done_next  = 1'b0;
`ifdef GPU_SCHED_TIMEOUT_EN
        err_set    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_total != 32'd0) state_next = ISSUE;
                    else                     done_next  = 1'b1;
                end
            end
            ISSUE: begin
                if (rect_valid && rect_ready) state_next = DRAIN;
            end
            DRAIN: begin
                if (pix_count + 32'(fb_write) == total) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
`ifdef GPU_SCHED_TIMEOUT_EN
                else if (!fb_write && wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    err_set    = 1'b1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Active draw registers change only when a command is popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rect_valid          <= 1'b0;
            draw_done           <= 1'b0;
            total               <= '0;
            pix_count           <= '0;
            rect_start_x        <= '0;
            rect_start_y        <= '0;
            rect_width          <= '0;
            rect_height         <= '0;
            rect_scale_x        <= '0;
            rect_scale_y        <= '0;
            rect_mirror_x       <= 1'b0;
            rect_mirror_y       <= 1'b0;
            cfg_base_address    <= '0;
            cfg_image_width     <= '0;
            cfg_ct_type         <= '0;
            cfg_use_ct          <= 1'b0;
            cfg_ct_base_address <= '0;
        end else begin
            rect_valid <= (state_next == ISSUE);
            draw_done  <= done_next;
            if (pop) begin
                total               <= head_total;
                pix_count           <= '0;
                rect_start_x        <= h_start_x;
                rect_start_y        <= h_start_y;
                rect_width          <= h_width;
                rect_height         <= h_height;
                rect_scale_x        <= h_scale_x;
                rect_scale_y        <= h_scale_y;
                rect_mirror_x       <= h_mirror_x;
                rect_mirror_y       <= h_mirror_y;
                cfg_base_address    <= h_base_address;
                cfg_image_width     <= h_image_width;
                cfg_ct_type         <= h_use_ct ? h_ct_type : 5'd16;
                cfg_use_ct          <= h_use_ct;
                cfg_ct_base_address <= h_ct_base_address;
            end else if (state != IDLE && fb_write) begin
                pix_count <= pix_count + 32'd1;
            end
        end
    end

`ifdef GPU_SCHED_TIMEOUT_EN
    // wd counts cycles since DRAIN entry or the last pixel, including the current one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd          <= '0;
            sched_error <= 1'b0;
        end else begin
            if (err_set) sched_error <= 1'b1;
            if ((state == ISSUE && state_next == DRAIN) || (state == DRAIN && fb_write))
                wd <= WD_W'(1);
            else if (state == DRAIN)
                wd <= wd + WD_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gpu_draw_scheduler.sv
// Scoreboard bench for gpu_draw_scheduler: random commands, random rect_ready and pixel
// pacing, checked against a command-level reference model.
module tb_gpu_draw_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_start_x, cmd_start_y, cmd_width, cmd_height, cmd_scale_x, cmd_scale_y;
    logic        cmd_mirror_x, cmd_mirror_y;
    logic [31:0] cmd_base_address;
    logic [15:0] cmd_image_width;
    logic [4:0]  cmd_ct_type;
    logic        cmd_use_ct;
    logic [15:0] cmd_ct_base_address;
    logic        rect_valid;
    logic        rect_ready = 1'b0;
    logic [15:0] rect_start_x, rect_start_y, rect_width, rect_height, rect_scale_x, rect_scale_y;
    logic        rect_mirror_x, rect_mirror_y;
    logic [31:0] cfg_base_address;
    logic [15:0] cfg_image_width;
    logic [4:0]  cfg_ct_type;
    logic        cfg_use_ct;
    logic [15:0] cfg_ct_base_address;
    logic        fb_write = 1'b0;
    logic        busy;
    logic        draw_done;
    logic [2:0]  pending;
`ifdef GPU_SCHED_TIMEOUT_EN
    logic        sched_error;
`endif

    always #5 clk = ~clk;

    gpu_draw_scheduler dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start_x(cmd_start_x), .cmd_start_y(cmd_start_y),
        .cmd_width(cmd_width), .cmd_height(cmd_height),
        .cmd_scale_x(cmd_scale_x), .cmd_scale_y(cmd_scale_y),
        .cmd_mirror_x(cmd_mirror_x), .cmd_mirror_y(cmd_mirror_y),
        .cmd_base_address(cmd_base_address), .cmd_image_width(cmd_image_width),
        .cmd_ct_type(cmd_ct_type), .cmd_use_ct(cmd_use_ct),
        .cmd_ct_base_address(cmd_ct_base_address),
        .rect_valid(rect_valid), .rect_ready(rect_ready),
        .rect_start_x(rect_start_x), .rect_start_y(rect_start_y),
        .rect_width(rect_width), .rect_height(rect_height),
        .rect_scale_x(rect_scale_x), .rect_scale_y(rect_scale_y),
        .rect_mirror_x(rect_mirror_x), .rect_mirror_y(rect_mirror_y),
        .cfg_base_address(cfg_base_address), .cfg_image_width(cfg_image_width),
        .cfg_ct_type(cfg_ct_type), .cfg_use_ct(cfg_use_ct),
        .cfg_ct_base_address(cfg_ct_base_address),
        .fb_write(fb_write), .busy(busy), .draw_done(draw_done), .pending(pending)
`ifdef GPU_SCHED_TIMEOUT_EN
        , .sched_error(sched_error)
`endif
    );

    typedef struct {
        logic [15:0] sx, sy, w, h, scx, scy;
        logic        mx, my;
        logic [31:0] base;
        logic [15:0] iw;
        logic [4:0]  ct;
        logic        use_ct;
        logic [15:0] ctb;
    } cmd_t;

    cmd_t exp_rect[$];
    cmd_t exp_done[$];
    cmd_t e_r, e_d;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   done_due  = -1;
    int   pix_left  = 0;
    int   pulses    = 0;
    int   rdy_mode  = 1;
    bit   eng_on    = 1'b0;
    bit   stray     = 1'b0;

    function automatic logic [31:0] total_of(input cmd_t c);
        return 32'(c.w) * 32'(c.h);
    endfunction

    function automatic logic [127:0] rect_pack(input cmd_t c);
        return 128'({c.sx, c.sy, c.w, c.h, c.scx, c.scy, c.mx, c.my});
    endfunction

    // Colour-table-less draws always present 16 bits per pixel.
    function automatic logic [127:0] cfg_pack(input cmd_t c);
        return 128'({c.base, c.iw, (c.use_ct ? c.ct : 5'd16), c.use_ct, c.ctb});
    endfunction

    function automatic cmd_t mk(input int w, input int h, input bit use_ct, input int ct);
        cmd_t c;
        c.sx = 16'($urandom); c.sy = 16'($urandom);
        c.w = 16'(w); c.h = 16'(h);
        c.scx = 16'($urandom); c.scy = 16'($urandom);
        c.mx = 1'($urandom_range(0, 1)); c.my = 1'($urandom_range(0, 1));
        c.base = $urandom; c.iw = 16'($urandom);
        c.ct = 5'(ct); c.use_ct = use_ct; c.ctb = 16'($urandom);
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        return mk($urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                  1 << $urandom_range(0, 4));
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Driver for rect_ready/fb_write plus the output monitor, all at the negedge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!eng_on) begin
            rect_ready = 1'b0;
            fb_write   = 1'b0;
        end else begin
            rect_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (stray) begin
                fb_write = 1'($urandom_range(0, 1));
            end else if (pix_left > 0 && $urandom_range(0, 3) != 0) begin
                fb_write = 1'b1;
                pix_left--;
                pulses++;
                if (pix_left == 0) done_due = cyc + 1;
            end else begin
                fb_write = 1'b0;
            end
            if (rect_valid && rect_ready) begin
                if (exp_rect.size() == 0) begin
                    check("rect_unexpected", 128'(exp_rect.size() != 0), 128'(1));
                end else begin
                    e_r = exp_rect.pop_front();
                    check("rect_fields", 128'({rect_start_x, rect_start_y, rect_width, rect_height,
                          rect_scale_x, rect_scale_y, rect_mirror_x, rect_mirror_y}), rect_pack(e_r));
                    check("cfg_fields", 128'({cfg_base_address, cfg_image_width, cfg_ct_type,
                          cfg_use_ct, cfg_ct_base_address}), cfg_pack(e_r));
                    pix_left = int'(total_of(e_r));
                end
            end
            if (draw_done) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 128'(exp_done.size() != 0), 128'(1));
                end else begin
                    e_d = exp_done.pop_front();
                    check("done_order", 128'(cfg_base_address), 128'(e_d.base));
                    if (total_of(e_d) != 0) check("done_timing", 128'(cyc), 128'(done_due));
                end
            end else if (cyc == done_due) begin
                check("done_missing", 128'(draw_done), 128'(1));
            end
        end
    end

    task automatic push(input cmd_t c);
        int n;
        @(negedge clk);
        cmd_start_x = c.sx; cmd_start_y = c.sy; cmd_width = c.w; cmd_height = c.h;
        cmd_scale_x = c.scx; cmd_scale_y = c.scy; cmd_mirror_x = c.mx; cmd_mirror_y = c.my;
        cmd_base_address = c.base; cmd_image_width = c.iw; cmd_ct_type = c.ct;
        cmd_use_ct = c.use_ct; cmd_ct_base_address = c.ctb;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("push_timeout", 128'(cmd_ready), 128'(1));
        end else begin
            exp_done.push_back(c);
            if (total_of(c) != 0) exp_rect.push_back(c);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((exp_done.size() != 0 || busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 128'(exp_done.size() == 0 && !busy), 128'(1));
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        cmd_t c;
        cmd_t burst[5];
        int   n;
        rst = 1'b0;
        cmd_valid = 1'b0;
        c = mk(0, 0, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        check("rst_rect_valid", 128'(rect_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_pending", 128'(pending), 128'(0));
        check("rst_draw_done", 128'(draw_done), 128'(0));
        check("rst_cfg_ct_type", 128'(cfg_ct_type), 128'(0));
        rst = 1'b1;
        eng_on = 1'b1;

        // 4x2 draw through the colour table
        rdy_mode = 1;
        push(mk(4, 2, 1'b1, 4));
        wait_idle(300);
        check("t1_cfg_ct_type", 128'(cfg_ct_type), 128'(4));
        check("t1_pending", 128'(pending), 128'(0));

        // 1x1 draw without colour table
        push(mk(1, 1, 1'b0, 4));
        wait_idle(300);
        check("t4_cfg_ct_type", 128'(cfg_ct_type), 128'(16));
        check("t4_cfg_use_ct", 128'(cfg_use_ct), 128'(0));

        // empty draw retires without a rectangle, then a normal one follows
        push(mk(0, 9, 1'b1, 2));
        check("t3_done_early", 128'(draw_done), 128'(0));
        check("t3_no_rect_a", 128'(rect_valid), 128'(0));
        @(negedge clk);
        check("t3_done_pulse", 128'(draw_done), 128'(1));
        check("t3_no_rect_b", 128'(rect_valid), 128'(0));
        push(mk(3, 3, 1'b1, 8));
        wait_idle(300);

        // queue fills while the rectangle stage stalls
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) burst[i] = mk($urandom_range(1, 4), $urandom_range(1, 4), 1'b1, 2);
        push(burst[0]);
        repeat (3) @(negedge clk);
        check("t2_rect_held", 128'(rect_valid), 128'(1));
        for (int i = 1; i < 5; i++) push(burst[i]);
        check("t2_pending_full", 128'(pending), 128'(4));
        check("t2_cmd_ready_low", 128'(cmd_ready), 128'(0));
        rdy_mode = 2;
        wait_idle(1000);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            push(rand_cmd());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        wait_idle(20000);

        // reset in the middle of a 16x16 drain
        rdy_mode = 1;
        pulses = 0;
        push(mk(16, 16, 1'b1, 16));
        n = 0;
        while (pulses < 100 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("t5_pulses_reached", 128'(pulses >= 100), 128'(1));
        #2;
        eng_on = 1'b0;
        rst = 1'b0;
        #1;
        check("t5_rect_valid", 128'(rect_valid), 128'(0));
        check("t5_draw_done", 128'(draw_done), 128'(0));
        check("t5_busy", 128'(busy), 128'(0));
        check("t5_pending", 128'(pending), 128'(0));
        check("t5_cfg_base", 128'(cfg_base_address), 128'(0));
        check("t5_rect_width", 128'(rect_width), 128'(0));
        check("t5_cmd_ready", 128'(cmd_ready), 128'(1));
        exp_rect.delete();
        exp_done.delete();
        pix_left = 0;
        done_due = -1;
        @(negedge clk);
        rst = 1'b1;
        stray = 1'b1;
        eng_on = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("t5_stray_no_done", 128'(draw_done), 128'(0));
        end
        stray = 1'b0;
        @(negedge clk);

        // scheduler recovers after reset
        push(mk(2, 2, 1'b1, 1));
        wait_idle(300);
`ifdef GPU_SCHED_TIMEOUT_EN
        check("no_sched_error", 128'(sched_error), 128'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
